// File: rtl/scytale_decryption.sv
// scytale_decryption: buffers an encrypted message and replays it column-major once the token arrives
// Ports: clk_sys/rst_n clock and async active-low reset; data_i/valid_i incoming characters;
//        key_N/key_M column/row count sampled at token; data_o/valid_o decrypted stream; busy while decrypting.
module scytale_decryption #(
  parameter int                   D_WIDTH                = 8,
  parameter int                   KEY_WIDTH              = 8,
  parameter int                   MAX_NOF_CHARS          = 50,
  parameter logic [D_WIDTH-1:0]   START_DECRYPTION_TOKEN = 8'hFA
) (
  input  logic                 clk_sys,
  input  logic                 rst_n,
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic                 valid_i,
  input  logic [KEY_WIDTH-1:0] key_N,
  input  logic [KEY_WIDTH-1:0] key_M,
  output logic [D_WIDTH-1:0]   data_o,
  output logic                 valid_o,
  output logic                 busy
);
  localparam int CW = $clog2(MAX_NOF_CHARS + 1);
  localparam int AW = (MAX_NOF_CHARS > 1) ? $clog2(MAX_NOF_CHARS) : 1;
  localparam int IW = (2 * KEY_WIDTH + 1 > 16) ? 2 * KEY_WIDTH + 1 : 16;
  localparam logic [CW-1:0] MAX_C = CW'(MAX_NOF_CHARS);
  typedef enum logic {COLLECT, DECRYPT} state_t;
  state_t               r_state, w_next;
  logic [D_WIDTH-1:0]   r_buf [MAX_NOF_CHARS];
  logic [CW-1:0]        r_count;
  logic [KEY_WIDTH-1:0] r_n, r_m, r_c, r_r;
  logic                 w_store, w_start, w_done, w_last_row;
  logic [IW-1:0]        w_idx;
  logic [D_WIDTH-1:0]   w_char;
  assign w_store    = r_state == COLLECT && valid_i && data_i != START_DECRYPTION_TOKEN && r_count < MAX_C;
  assign w_start    = r_state == COLLECT && valid_i && data_i == START_DECRYPTION_TOKEN && r_count != '0;
  // column pointer walks past the last column when every character has been emitted
  assign w_done     = r_c >= r_n || r_m == '0;
  assign w_last_row = r_r == r_m - 1'b1;
  assign w_idx      = IW'(r_r) * IW'(r_n) + IW'(r_c);
  // positions never written read back as zero
  assign w_char     = w_idx < IW'(r_count) ? r_buf[w_idx[AW-1:0]] : '0;
  always_comb begin
    w_next = r_state;
    if (r_state == COLLECT) w_next = w_start ? DECRYPT : COLLECT;
    else                    w_next = w_done ? COLLECT : DECRYPT;
  end
  always_ff @(posedge clk_sys or negedge rst_n)
    if (!rst_n) r_state <= COLLECT;
    else        r_state <= w_next;
  always_ff @(posedge clk_sys)
    if (w_store) r_buf[r_count[AW-1:0]] <= data_i;
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_n     <= '0;
      r_m     <= '0;
      r_c     <= '0;
      r_r     <= '0;
      data_o  <= '0;
      valid_o <= 1'b0;
      busy    <= 1'b0;
    end else if (r_state == COLLECT) begin
      data_o  <= '0;
      valid_o <= 1'b0;
      if (w_store) r_count <= r_count + 1'b1;
      if (w_start) begin
        r_n  <= key_N;
        r_m  <= key_M;
        r_c  <= '0;
        r_r  <= '0;
        busy <= 1'b1;
      end
    end else if (w_done) begin
      data_o  <= '0;
      valid_o <= 1'b0;
      busy    <= 1'b0;
      r_count <= '0;
    end else begin
      data_o  <= w_char;
      valid_o <= 1'b1;
      r_r     <= w_last_row ? '0 : r_r + 1'b1;
      r_c     <= w_last_row ? r_c + 1'b1 : r_c;
    end
  end
endmodule

// File: tb/tb_scytale_decryption.sv
// tb_scytale_decryption: randomized and directed checks of scytale_decryption against a queue-based model
module tb_scytale_decryption;
  localparam logic [7:0] TOK = 8'hFA;
  logic       clk_sys = 1'b0;
  logic       rst_n   = 1'b0;
  logic [7:0] data_i  = '0;
  logic       valid_i = 1'b0;
  logic [7:0] key_N   = '0;
  logic [7:0] key_M   = '0;
  logic [7:0] data_o;
  logic       valid_o;
  logic       busy;
  int errors = 0;
  int checks = 0;
  scytale_decryption dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i),
    .key_N(key_N), .key_M(key_M), .data_o(data_o), .valid_o(valid_o), .busy(busy)
  );
  always #5 clk_sys = ~clk_sys;
  task automatic to_q(input string s, output logic [7:0] q[$]);
    q = {};
    for (int i = 0; i < s.len(); i++) q.push_back(8'(s[i]));
  endtask
  task automatic gen(input int len, output logic [7:0] q[$]);
    q = {};
    for (int i = 0; i < len; i++) q.push_back(8'($urandom_range(0, 249)));
  endtask
  // reference: buffer keeps the first 50 characters; read column-major, missing positions are zero
  task automatic model(input logic [7:0] msg[$], input int n, input int m, output logic [7:0] exp[$]);
    exp = {};
    for (int c = 0; c < n; c++)
      for (int r = 0; r < m; r++) begin
        int idx = r * n + c;
        exp.push_back((idx < msg.size() && idx < 50) ? msg[idx] : 8'h00);
      end
  endtask
  task automatic send_msg(input logic [7:0] msg[$]);
    foreach (msg[i]) begin
      if ($urandom_range(0, 3) == 0) begin
        valid_i = 1'b0;
        data_i  = 8'($urandom);
        @(posedge clk_sys); #1;
      end
      data_i  = msg[i];
      valid_i = 1'b1;
      @(posedge clk_sys); #1;
    end
    valid_i = 1'b0;
  endtask
  task automatic send_token;
    data_i  = TOK;
    valid_i = 1'b1;
    @(posedge clk_sys); #1;
    valid_i = 1'b0;
    data_i  = 8'($urandom);
  endtask
  // observes from the token edge until busy drops; optionally floods junk input while busy
  task automatic capture(input bit junk, output int bcyc, output logic [7:0] outs[$], output int bad0, output bit tmo);
    bcyc = 0; bad0 = 0; outs = {}; tmo = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (valid_o) outs.push_back(data_o);
      else if (data_o !== 8'h00) bad0++;
      if (busy !== 1'b1) begin
        tmo = 1'b0;
        break;
      end
      bcyc++;
      if (junk) begin
        data_i  = 8'h58 + 8'(i % 3);
        valid_i = 1'b1;
        key_N   = key_N ^ 8'h01;
      end
      @(posedge clk_sys); #1;
    end
    valid_i = 1'b0;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
    checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_o); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    @(negedge clk_sys) rst_n = 1'b1;
    @(posedge clk_sys); #1;
  endtask
  task automatic test_token_first;
    logic [7:0] msg[$], exp[$], outs[$];
    int bcyc, bad0;
    bit tmo;
    send_token;
    capture(1'b0, bcyc, outs, bad0, tmo);
    checks++; if (bcyc !== 0 || outs.size() !== 0) begin errors++; $display("FAIL early_token busy_cycles=%0d outputs=%0d want 0/0", bcyc, outs.size()); end
    key_N = 8'd2; key_M = 8'd3;
    to_q("ADBECF", msg);
    to_q("ABCDEF", exp);
    send_msg(msg);
    send_token;
    capture(1'b0, bcyc, outs, bad0, tmo);
    checks++; if (tmo || bcyc !== 7) begin errors++; $display("FAIL basic_busy got %0d want 7 (timeout=%0b)", bcyc, tmo); end
    checks++; if (outs.size() !== 6) begin errors++; $display("FAIL basic_count got %0d want 6", outs.size()); end
    foreach (exp[i]) if (i < outs.size()) begin
      checks++; if (outs[i] !== exp[i]) begin errors++; $display("FAIL basic_char[%0d] got %h want %h", i, outs[i], exp[i]); end
    end
  endtask
  task automatic test_random;
    logic [7:0] msg[$], exp[$], outs[$];
    int bcyc, bad0, n, m;
    bit tmo;
    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(0, 8);
      m = $urandom_range(0, 8);
      gen($urandom_range(1, 60), msg);
      model(msg, n, m, exp);
      key_N = 8'(n); key_M = 8'(m);
      send_msg(msg);
      send_token;
      capture(1'b0, bcyc, outs, bad0, tmo);
      checks++; if (tmo || bcyc !== exp.size() + 1) begin errors++; $display("FAIL rand%0d_busy got %0d want %0d", t, bcyc, exp.size() + 1); end
      checks++; if (outs.size() !== exp.size()) begin errors++; $display("FAIL rand%0d_count got %0d want %0d", t, outs.size(), exp.size()); end
      checks++; if (bad0 !== 0) begin errors++; $display("FAIL rand%0d_idle_data got %0d nonzero want 0", t, bad0); end
      foreach (exp[i]) if (i < outs.size()) begin
        checks++; if (outs[i] !== exp[i]) begin errors++; $display("FAIL rand%0d_char[%0d] got %h want %h", t, i, outs[i], exp[i]); end
      end
    end
  endtask
  task automatic test_overflow;
    logic [7:0] msg[$], exp[$], outs[$];
    int bcyc, bad0;
    bit tmo;
    gen(52, msg);
    model(msg, 5, 10, exp);
    key_N = 8'd5; key_M = 8'd10;
    send_msg(msg);
    send_token;
    capture(1'b0, bcyc, outs, bad0, tmo);
    checks++; if (tmo || bcyc !== 51) begin errors++; $display("FAIL ovf_busy got %0d want 51", bcyc); end
    checks++; if (outs.size() !== 50) begin errors++; $display("FAIL ovf_count got %0d want 50", outs.size()); end
    foreach (exp[i]) if (i < outs.size()) begin
      checks++; if (outs[i] !== exp[i]) begin errors++; $display("FAIL ovf_char[%0d] got %h want %h", i, outs[i], exp[i]); end
    end
  endtask
  task automatic test_ignore_during_decrypt;
    logic [7:0] msg[$], exp[$], outs[$];
    int bcyc, bad0;
    bit tmo;
    key_N = 8'd2; key_M = 8'd3;
    to_q("ADBECF", msg);
    to_q("ABCDEF", exp);
    send_msg(msg);
    send_token;
    capture(1'b1, bcyc, outs, bad0, tmo);
    key_N = 8'd2;
    checks++; if (tmo || bcyc !== 7) begin errors++; $display("FAIL junk_busy got %0d want 7", bcyc); end
    checks++; if (outs.size() !== 6) begin errors++; $display("FAIL junk_count got %0d want 6", outs.size()); end
    foreach (exp[i]) if (i < outs.size()) begin
      checks++; if (outs[i] !== exp[i]) begin errors++; $display("FAIL junk_char[%0d] got %h want %h", i, outs[i], exp[i]); end
    end
    send_token;
    capture(1'b0, bcyc, outs, bad0, tmo);
    checks++; if (bcyc !== 0) begin errors++; $display("FAIL junk_count_cleared busy_cycles got %0d want 0", bcyc); end
  endtask
  task automatic test_reset_mid;
    logic [7:0] msg[$];
    logic [7:0] third;
    int got, vcnt;
    key_N = 8'd2; key_M = 8'd3;
    to_q("ADBECF", msg);
    send_msg(msg);
    send_token;
    got = 0; third = 8'h00;
    for (int i = 0; i < 20 && got < 3; i++) begin
      @(posedge clk_sys); #1;
      if (valid_o) begin
        got++;
        third = data_o;
      end
    end
    checks++; if (got !== 3 || third !== 8'h43) begin errors++; $display("FAIL rmid_third got %0d outputs last=%h want 3 last=43", got, third); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", valid_o); end
    checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL rmid_data got %h want 00", data_o); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
    #1 rst_n = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk_sys); #1;
      if (valid_o || busy) vcnt++;
    end
    checks++; if (vcnt !== 0) begin errors++; $display("FAIL rmid_quiet got %0d active cycles want 0", vcnt); end
    send_token;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_count_cleared busy got %b want 0", busy); end
  endtask
  task automatic test_small_keys;
    logic [7:0] msg[$], outs[$];
    int bcyc, bad0;
    bit tmo;
    key_N = 8'd3; key_M = 8'd1;
    to_q("ABC", msg);
    send_msg(msg);
    send_token;
    capture(1'b0, bcyc, outs, bad0, tmo);
    checks++; if (tmo || bcyc !== 4) begin errors++; $display("FAIL k31_busy got %0d want 4", bcyc); end
    checks++; if (outs.size() !== 3) begin errors++; $display("FAIL k31_count got %0d want 3", outs.size()); end
    else begin
      checks++; if (outs[0] !== 8'h41 || outs[1] !== 8'h42 || outs[2] !== 8'h43) begin errors++; $display("FAIL k31_chars got %h%h%h want 414243", outs[0], outs[1], outs[2]); end
    end
    key_N = 8'd0;
    to_q("Q", msg);
    send_msg(msg);
    send_token;
    capture(1'b0, bcyc, outs, bad0, tmo);
    checks++; if (tmo || bcyc !== 1) begin errors++; $display("FAIL kzero_busy got %0d want 1", bcyc); end
    checks++; if (outs.size() !== 0) begin errors++; $display("FAIL kzero_count got %0d want 0", outs.size()); end
    send_token;
    capture(1'b0, bcyc, outs, bad0, tmo);
    checks++; if (bcyc !== 0) begin errors++; $display("FAIL kzero_count_cleared busy_cycles got %0d want 0", bcyc); end
  endtask
  initial begin
    test_reset;
    test_token_first;
    test_random;
    test_overflow;
    test_ignore_during_decrypt;
    test_reset_mid;
    test_small_keys;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/scytale_decryption.md
SCYTALE_DECRYPTION -- requirements
Module: scytale_decryption

Interface
REQ-001 SHALL have parameter D_WIDTH, default 8, character width in bits.
REQ-002 SHALL have parameter KEY_WIDTH, default 8, width of each key port.
REQ-003 SHALL have parameter MAX_NOF_CHARS, default 50, character buffer depth.
REQ-004 SHALL have parameter START_DECRYPTION_TOKEN, default 8'hFA, end-of-message marker.
REQ-005 SHALL have port clk_sys, input, 1, sole clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port data_i, input, D_WIDTH, encrypted character from the demux channel-1 output.
REQ-008 SHALL have port valid_i, input, 1, data_i qualifier.
REQ-009 SHALL have port key_N, input, KEY_WIDTH, column count.
REQ-010 SHALL have port key_M, input, KEY_WIDTH, row count.
REQ-011 SHALL have port data_o, output, D_WIDTH, decrypted character.
REQ-012 SHALL have port valid_o, output, 1, data_o qualifier.
REQ-013 SHALL have port busy, output, 1, high while decrypting; new input ignored.

Function
REQ-014 SHALL implement two states: COLLECT (default) and DECRYPT.
REQ-015 In COLLECT, a valid_i=1 edge with data_i != token and write count < MAX_NOF_CHARS SHALL store data_i at buffer[count] and increment count.
REQ-016 In COLLECT, a valid_i=1 edge with count = MAX_NOF_CHARS and data_i != token SHALL drop the character; count holds, and no other state changes.
REQ-017 In COLLECT, a valid_i=1 edge with data_i = token and count > 0 SHALL sample key_N and key_M, enter DECRYPT and set busy=1 from that edge; valid_o stays 0.
REQ-018 A token received with count = 0 SHALL be ignored: the block stays in COLLECT and produces no output.
REQ-019 The token SHALL never be stored in the buffer.
REQ-020 In DECRYPT, each rising edge SHALL emit one character with valid_o=1, in total L = key_N*key_M characters on consecutive cycles.
REQ-021 Output order SHALL be: for column c = 0..key_N-1 (outer), for row r = 0..key_M-1 (inner), emit buffer[r*key_N + c].
REQ-022 Buffer indices at or beyond count SHALL read as 0 on data_o; the index arithmetic SHALL be at least 16 bits wide with no truncation.
REQ-023 On the edge after the L-th character, the block SHALL set valid_o=0, data_o=0 and busy=0, clear count to 0 and return to COLLECT.
REQ-024 valid_i SHALL be ignored throughout DECRYPT, including a token or data arriving on the same edge as DECRYPT exit.
REQ-025 key_N and key_M changes during DECRYPT SHALL have no effect; the sampled values apply.
REQ-026 data_o SHALL be 0 whenever valid_o=0.
REQ-027 key_N=0 or key_M=0 at token acceptance SHALL give L=0: busy is high for exactly one cycle with no valid_o pulse, then the block returns to COLLECT with count cleared.
REQ-028 For L >= 1, busy SHALL be high for exactly L+1 cycles, and valid_o SHALL be high for exactly the last L of them.

Reset
REQ-029 rst_n=0 SHALL immediately, independent of clk_sys, force data_o=0, valid_o=0, busy=0, count=0, and state COLLECT.
REQ-030 Buffer contents need not be cleared by reset, but no stale character SHALL be emitted after reset.
REQ-031 A reset asserted mid-DECRYPT SHALL abort output with no further valid_o pulses until a new message and token are received.

Verification
REQ-032 key_N=2, key_M=3, feed "ADBECF" then 8'hFA -> busy=1 for 7 cycles; data_o = A,B,C,D,E,F on 6 consecutive valid_o cycles.
REQ-033 8'hFA as the first character after reset -> valid_o and busy remain 0; then "ADBECF"+FA decrypts as in REQ-032.
REQ-034 52 non-token characters then FA with key_N=5, key_M=10 -> 50 outputs; the last 2 input characters never appear.
REQ-035 During DECRYPT drive valid_i=1 with "XYZ" and toggle key_N -> output identical to REQ-032; after busy falls, count=0.
REQ-036 rst_n pulsed low mid-clock after the 3rd output of REQ-032 -> outputs drop to 0 asynchronously; no further valid_o until a new message.
REQ-037 key_N=3, key_M=1, feed "ABC" then FA -> outputs A,B,C; then key_N=0 with "Q" then FA -> busy high 1 cycle, no valid_o.
